// File: rtl/pool_relu_quant.sv
// Max-pool / ReLU / shift / saturate stage for the conv_112_49 output stream.
// The result leaves through a two-entry FIFO, and out_last marks each frame end.
module pool_relu_quant #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 12,
  parameter int POOL  = 2,
  parameter int FRAME = 64,
  parameter int SHIFT = 8,
  parameter int RELU  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int WCW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int FCW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(POOL - 1);
  localparam logic [WCW-1:0] WIN_ONE  = WCW'(1);
  localparam logic [FCW-1:0] FRM_LAST = FCW'(FRAME - 1);
  localparam logic [FCW-1:0] FRM_ONE  = FCW'(1);
  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = ~SAT_HI;

  logic [WCW-1:0]         win_cnt_q, win_cnt_d;
  logic [FCW-1:0]         frm_cnt_q, frm_cnt_d;
  logic signed [IN_W-1:0] max_q, max_d;
  logic [OUT_W-1:0]       head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                   head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [1:0]             cnt_q, cnt_d;

  logic                   accept, close, pop, frm_end, win_end;
  logic signed [IN_W-1:0] sample, win_max, relu_v, shifted;
  logic [OUT_W-1:0]       sat;

  // Valid/ready: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready comes only from registered FIFO occupancy, so out_ready never reaches it.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_last  = head_last_q;

  assign accept  = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign frm_end = (frm_cnt_q == FRM_LAST);
  assign win_end = (win_cnt_q == WIN_LAST);
  assign close   = accept && (win_end || frm_end);

  // The closing sample takes part in the max, so the result is ready on the same edge.
  always_comb begin
    sample  = $signed(in_data);
    win_max = ((win_cnt_q == '0) || (sample > max_q)) ? sample : max_q;
    relu_v  = ((RELU != 0) && win_max[IN_W-1]) ? '0 : win_max;
    shifted = relu_v >>> SHIFT;
    if (shifted > SAT_HI) begin
      sat = SAT_HI[OUT_W-1:0];
    end else if (shifted < SAT_LO) begin
      sat = SAT_LO[OUT_W-1:0];
    end else begin
      sat = shifted[OUT_W-1:0];
    end
  end

  always_comb begin
    win_cnt_d = win_cnt_q;
    frm_cnt_d = frm_cnt_q;
    max_d     = max_q;
    if (accept) begin
      max_d     = win_max;
      win_cnt_d = close ? '0 : win_cnt_q + WIN_ONE;
      frm_cnt_d = frm_end ? '0 : frm_cnt_q + FRM_ONE;
    end
  end

  // Slot 0 is the head. A push while full cannot occur because accept needs in_ready.
  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    cnt_d       = cnt_q;
    case ({close, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_data_d = sat;
          head_last_d = frm_end;
        end else begin
          tail_data_d = sat;
          tail_last_d = frm_end;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        cnt_d       = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_data_d = sat;
          head_last_d = frm_end;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = sat;
          tail_last_d = frm_end;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_q   <= '0;
      frm_cnt_q   <= '0;
      max_q       <= '0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      frm_cnt_q   <= frm_cnt_d;
      max_q       <= max_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pool_relu_quant.sv
// Directed and table-driven bench for pool_relu_quant. It uses a default instance,
// a RELU=0 instance and a POOL=3 instance.
module tb_pool_relu_quant;
  localparam int IN_W  = 26;
  localparam int OUT_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;

  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0, in_ready, out_valid, out_last, out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;

  logic [IN_W-1:0]  b_data = '0;
  logic             b_valid = 1'b0, b_in_ready, b_out_valid, b_out_last;
  logic             b_out_ready = 1'b1;
  logic [OUT_W-1:0] b_out_data;

  logic [IN_W-1:0]  c_data = '0;
  logic             c_valid = 1'b0, c_in_ready, c_out_valid, c_out_last;
  logic             c_out_ready = 1'b1;
  logic [OUT_W-1:0] c_out_data;

  pool_relu_quant dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  pool_relu_quant #(.RELU(0)) dut_norelu (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last)
  );

  pool_relu_quant #(.POOL(3)) dut_pool3 (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_last(c_out_last)
  );

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [OUT_W:0] exp_q[$];
  logic [OUT_W:0] rx_hist[$];
  logic [OUT_W:0] e;
  logic signed [IN_W-1:0] seq[128];

  typedef struct {
    logic signed [IN_W-1:0]  a;
    logic signed [IN_W-1:0]  b;
    logic signed [OUT_W-1:0] exp;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [OUT_W-1:0] quant(input longint m);
    longint r, s;
    r = (m < 0) ? 0 : m;
    s = r >>> 8;
    if (s > 2047) s = 2047;
    else if (s < -2048) s = -2048;
    return s[OUT_W-1:0];
  endfunction

  // Golden reference for the default instance: POOL=2, FRAME=64, RELU=1.
  task automatic model_push(input int n);
    longint m;
    int w;
    int f;
    m = 0;
    w = 0;
    for (int i = 0; i < n; i++) begin
      f = i % 64;
      if (w == 0 || longint'(seq[i]) > m) m = longint'(seq[i]);
      if (w == 1 || f == 63) begin
        exp_q.push_back({(f == 63), quant(m)});
        w = 0;
      end else begin
        w++;
      end
    end
  endtask

  // Scoreboard for the default instance. Transfers are sampled after the drivers settle.
  always @(negedge clk) begin
    #2;
    if (reset && out_valid && out_ready) begin
      rx_hist.push_back({out_last, out_data});
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_out_data", longint'($signed(out_data)), longint'($signed(e[OUT_W-1:0])));
        check("sb_out_last", out_last, e[OUT_W]);
      end
    end
  end

  int c_n = 0, c_bad = 0, c_last = 0, c_last_idx = 0;
  always @(negedge clk) begin
    #2;
    if (reset && c_out_valid && c_out_ready) begin
      c_n++;
      if (c_out_data != 12'd2) c_bad++;
      if (c_out_last) begin
        c_last++;
        c_last_idx = c_n;
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] d);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("in_ready_timeout", 0, 1);
    if (t > 0) stalls++;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_all_outputs", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rx_hist.delete();
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int k, cyc, lasts;
    logic fire;
    int tmp;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // Pair vectors: each pair is one window, and its result is visible one cycle after the second accept
    vt[0] = '{26'sd213640, 26'sd211680, 12'sd834};
    vt[1] = '{26'sd1000000, 26'sd5, 12'sd2047};
    vt[2] = '{-26'sd5000, -26'sd6000, 12'sd0};
    vt[3] = '{26'sd300, 26'sd100, 12'sd1};
    vt[4] = '{26'sd33554431, 26'sd0, 12'sd2047};
    vt[5] = '{-26'sd33554432, -26'sd1, 12'sd0};
    vt[6] = '{-26'sd1, 26'sd1000, 12'sd3};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({1'b0, vt[i].exp});
      send(vt[i].a);
      send(vt[i].b);
      @(negedge clk);
      in_valid = 1'b0;
      check("pair_latency_valid", out_valid, 1);
      check("pair_out_data", longint'($signed(out_data)), longint'(vt[i].exp));
      check("pair_out_last", out_last, 0);
      @(negedge clk);
      check("pair_fifo_empty", out_valid, 0);
    end

    // Two-frame convolution stream with full throughput
    do_reset();
    for (int i = 0; i < 64; i++) seq[i] = 26'(213640 - 1960 * i);
    for (int i = 0; i < 64; i++) seq[64 + i] = 26'(13328 + 441 * i);
    model_push(128);
    stalls = 0;
    for (int i = 0; i < 128; i++) send(seq[i]);
    idle();
    drain();
    check("stream_no_bubbles", stalls, 0);
    check("stream_out_count", rx_hist.size(), 64);
    check("stream_out0", rx_hist[0], {1'b0, 12'd834});
    check("stream_out31", rx_hist[31], {1'b1, 12'd359});
    check("stream_out32", rx_hist[32], {1'b0, 12'd53});
    check("stream_out63", rx_hist[63], {1'b1, 12'd160});
    lasts = 0;
    foreach (rx_hist[i]) if (rx_hist[i][OUT_W]) lasts++;
    check("stream_last_count", lasts, 2);
    check("idle_out_valid", out_valid, 0);

    // Backpressure followed by random valid/ready over two frames
    do_reset();
    for (int i = 0; i < 128; i++) begin
      if ($urandom_range(0, 3) == 0) tmp = int'($urandom());
      else tmp = int'($urandom_range(0, 400000)) - 200000;
      seq[i] = 26'(tmp);
    end
    model_push(128);
    k = 0;
    cyc = 0;
    fire = 1'b0;
    while (k < 128 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (fire) begin
        k++;
        in_valid = 1'b0;
      end
      if (k < 128 && !in_valid && (cyc <= 20 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = seq[k];
      end
      out_ready = (cyc <= 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
      fire = in_valid && in_ready;
      if (cyc == 20) begin
        check("bp_accepted", k, 4);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
      end
    end
    check("rand_all_sent", k, 128);
    idle();
    drain();
    check("rand_out_count", rx_hist.size(), 64);
    check("rand_idle", out_valid, 0);

    // Reset in the middle of a frame with a result still waiting
    do_reset();
    out_ready = 1'b0;
    send(26'sd1000);
    send(26'sd2000);
    send(26'sd3000);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    exp_q.delete();
    rx_hist.delete();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) seq[i] = 26'(i * 1000 - 30000);
    model_push(64);
    for (int i = 0; i < 64; i++) send(seq[i]);
    idle();
    drain();
    check("post_reset_out_count", rx_hist.size(), 32);

    // RELU=0 instance: floor toward -inf for negative results
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = -26'sd5000;
    @(negedge clk);
    b_data  = -26'sd6000;
    @(negedge clk);
    b_valid = 1'b0;
    check("norelu_valid", b_out_valid, 1);
    check("norelu_floor", longint'($signed(b_out_data)), -20);
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = -26'sd1000000;
    @(negedge clk);
    b_data  = -26'sd1;
    @(negedge clk);
    b_valid = 1'b0;
    check("norelu_minus1", longint'($signed(b_out_data)), -1);

    // POOL=3 instance: 64 samples of 512 give 22 outputs, and the last window holds one sample
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!c_in_ready) stalls++;
      c_valid = 1'b1;
      c_data  = 26'd512;
    end
    @(negedge clk);
    c_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pool3_no_stall", stalls, 0);
    check("pool3_count", c_n, 22);
    check("pool3_values", c_bad, 0);
    check("pool3_last_count", c_last, 1);
    check("pool3_last_index", c_last_idx, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
